bootprom_ctrl: RTL

BOOTPROM_CTRL -- requirements
Module: bootprom_ctrl

---
 rtl/bootprom_pkg.sv | 22 ++
 rtl/bootprom_ctrl_if.sv | 44 ++++
 rtl/bootprom_rr_arb.sv | 34 +++
 rtl/bootprom_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/bootprom_pkg.sv
// Shared types and constants for the dual-27256 boot PROM controller.
// Imported by the interface, the arbiter and the controller top.
package bootprom_pkg;

  localparam int ADDR_W          = 15;
  localparam int DATA_W          = 16;
  localparam int BYTE_W          = 8;
  localparam int WAIT_CYCLES_DEF = 3;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ACK
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_load(input int wait_cycles);
    return CNT_W'(wait_cycles);
  endfunction

endpackage

// File: rtl/bootprom_ctrl_if.sv
// Requester ports (CPU, debug loader) and the shared PROM bus.
// master = controller side, slave = requesters and PROM devices.
interface bootprom_ctrl_if;
  import bootprom_pkg::*;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_data;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ce_n;
  logic              rom_oe_n;
  logic [BYTE_W-1:0] rom_d_h;
  logic [BYTE_W-1:0] rom_d_l;

  logic              busy;

  modport master (
    input  cpu_req, cpu_addr,
    input  dbg_req, dbg_addr,
    input  rom_d_h, rom_d_l,
    output cpu_ack, cpu_data,
    output dbg_ack, dbg_data,
    output rom_addr, rom_ce_n, rom_oe_n,
    output busy
  );

  modport slave (
    output cpu_req, cpu_addr,
    output dbg_req, dbg_addr,
    output rom_d_h, rom_d_l,
    input  cpu_ack, cpu_data,
    input  dbg_ack, dbg_data,
    input  rom_addr, rom_ce_n, rom_oe_n,
    input  busy
  );

endinterface

// File: rtl/bootprom_rr_arb.sv
// Two-port round-robin arbiter; grant[0]=CPU, grant[1]=debug.
// The pointer moves away from whoever was served on i_done.
module bootprom_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req_cpu,
  input  logic       i_req_dbg,
  input  logic       i_done,
  output logic [1:0] o_grant
);

  logic r_prio_dbg;

  // Conditions are mutually exclusive, so the decoder is truly unique.
  always_comb begin
    o_grant = 2'b00;
    unique case (1'b1)
      (i_req_cpu && !(i_req_dbg && r_prio_dbg)):
        o_grant = 2'b01;
      (i_req_dbg && !(i_req_cpu && !r_prio_dbg)):
        o_grant = 2'b10;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_dbg <= 1'b0;
    end else if (i_done && (o_grant != 2'b00)) begin
      r_prio_dbg <= o_grant[0];
    end
  end

endmodule

// File: rtl/bootprom_ctrl.sv
// Boot PROM controller: arbitrates CPU and debug reads onto two
// byte-wide 27256 PROMs with a SETUP / ACCESS / ACK bus cycle.
module bootprom_ctrl
  import bootprom_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  bootprom_ctrl_if.master io_bus
);

  localparam logic [CNT_W-1:0] W_LOAD = cnt_load(WAIT_CYCLES);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_gnt_dbg;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic [DATA_W-1:0] r_cpu_data;
  logic [DATA_W-1:0] r_dbg_data;
  logic              r_busy;

  logic [1:0]        w_grant;
  logic              w_take;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_rom_word;

  // Requests are only looked at in IDLE; a taken grant advances the pointer.
  assign w_take     = (r_state == IDLE) && (w_grant != 2'b00);
  assign w_req_addr = w_grant[1] ? io_bus.dbg_addr
                                 : io_bus.cpu_addr;
  assign w_rom_word = {io_bus.rom_d_h, io_bus.rom_d_l};

  bootprom_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_cpu (io_bus.cpu_req),
    .i_req_dbg (io_bus.dbg_req),
    .i_done    (w_take),
    .o_grant   (w_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_gnt_dbg  <= 1'b0;
      r_rom_addr <= '0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_cpu_ack  <= 1'b0;
      r_dbg_ack  <= 1'b0;
      r_cpu_data <= '0;
      r_dbg_data <= '0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state    <= SETUP;
            r_gnt_dbg  <= w_grant[1];
            r_rom_addr <= w_req_addr;
            r_ce_n     <= 1'b0;
            r_oe_n     <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          r_oe_n  <= 1'b0;
          r_cnt   <= W_LOAD;
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= ACK;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            if (r_gnt_dbg) begin
              r_dbg_data <= w_rom_word;
              r_dbg_ack  <= 1'b1;
            end else begin
              r_cpu_data <= w_rom_word;
              r_cpu_ack  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACK: begin
          r_state   <= IDLE;
          r_cpu_ack <= 1'b0;
          r_dbg_ack <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_bus.cpu_ack  = r_cpu_ack;
  assign io_bus.cpu_data = r_cpu_data;
  assign io_bus.dbg_ack  = r_dbg_ack;
  assign io_bus.dbg_data = r_dbg_data;
  assign io_bus.rom_addr = r_rom_addr;
  assign io_bus.rom_ce_n = r_ce_n;
  assign io_bus.rom_oe_n = r_oe_n;
  assign io_bus.busy     = r_busy;

endmodule
